ats21_alarm_collector: RTL and testbench

Downstream consumer of the ATS21 alarm/timer outputs. It takes the 24-bit `data` vector, where each bit is one alarm's finished flag and is held high for about 2 cycles. It detects rising edges, queues one event per edge as {alarm id, timestamp} in a small FIFO, and presents the events to a host reader through a show-ahead pop interface. It also raises an interrupt and records events lost to coalescing.

---
 rtl/ats21_alarm_collector.sv | 170 +++++++++++++++++
 tb/tb_ats21_alarm_collector.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ats21_alarm_collector.sv
`default_nettype none
// ============================================================================
// Module   : ats21_alarm_collector
// Purpose  : Edge-detects the ATS21 alarm finished flags, queues one
//            {alarm id, timestamp} event per rising edge in a small FIFO and
//            presents the events on a show-ahead pop interface. Repeated
//            rises on an alarm that is still waiting to be queued are
//            coalesced and counted as drops.
// Revision : 1.0 - initial release
// ============================================================================
module ats21_alarm_collector #(
  parameter int NUM_ALARMS = 24,
  parameter int DEPTH      = 8,
  parameter int TS_WIDTH   = 16,
  parameter int ID_WIDTH   = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_ALARMS-1:0]    alarm_in,
  input  logic                     enable,
  input  logic                     rd_en,
  input  logic                     clear_ovf,
  output logic                     evt_valid,
  output logic [ID_WIDTH-1:0]      evt_id,
  output logic [TS_WIDTH-1:0]      evt_ts,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic [7:0]               drop_count,
  output logic                     irq
);

  localparam int C_PTR_W = $clog2(DEPTH);
  localparam int C_CNT_W = C_PTR_W + 1;
  localparam int C_POP_W = $clog2(NUM_ALARMS + 1);
  localparam logic [C_CNT_W-1:0] C_DEPTH = C_CNT_W'(DEPTH);

  // Input history, pending alarms and free-running timestamp
  logic [NUM_ALARMS-1:0] r_alarm_q;
  logic [NUM_ALARMS-1:0] r_pending;
  logic [TS_WIDTH-1:0]   r_ts_cnt;

  // Event FIFO storage and bookkeeping
  logic [ID_WIDTH-1:0]   r_mem_id [DEPTH];
  logic [TS_WIDTH-1:0]   r_mem_ts [DEPTH];
  logic [C_PTR_W-1:0]    r_wr_ptr;
  logic [C_PTR_W-1:0]    r_rd_ptr;
  logic [C_CNT_W-1:0]    r_count;

  // Loss reporting
  logic                  r_overflow;
  logic [7:0]            r_drop_count;

  logic [NUM_ALARMS-1:0] w_rise;
  logic [NUM_ALARMS-1:0] w_new;
  logic [NUM_ALARMS-1:0] w_sel_onehot;
  logic [NUM_ALARMS-1:0] w_clr_sel;
  logic [NUM_ALARMS-1:0] w_coal;
  logic [NUM_ALARMS-1:0] w_pending_nxt;
  logic [ID_WIDTH-1:0]   w_sel_idx;
  logic [C_POP_W-1:0]    w_coal_cnt;
  logic [7:0]            w_drop_base;
  logic [8:0]            w_drop_sum;
  logic [7:0]            w_drop_nxt;
  logic                  w_ovf_nxt;
  logic                  w_pop;
  logic                  w_push;

  assign w_rise = alarm_in & ~r_alarm_q;
  assign w_new  = w_rise & {NUM_ALARMS{enable}};

  // Lowest pending alarm wins the single enqueue slot of the cycle
  assign w_sel_onehot = r_pending & (~r_pending + NUM_ALARMS'(1));

  // Binary index of the lowest pending alarm
  always_comb begin
    w_sel_idx = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (r_pending[i]) begin
        w_sel_idx = ID_WIDTH'(i);
      end
    end
  end

  // A pop frees a slot in the same edge, so a full FIFO can still accept
  assign w_pop  = rd_en & evt_valid;
  assign w_push = (r_pending != '0) & ((r_count != C_DEPTH) | w_pop);

  // A new rise on the alarm being queued now is a fresh event, not a drop
  assign w_clr_sel     = w_push ? w_sel_onehot : '0;
  assign w_coal        = w_new & r_pending & ~w_clr_sel;
  assign w_pending_nxt = (r_pending & ~w_clr_sel) | w_new;

  // Several alarms may coalesce in the same cycle; count every one
  always_comb begin
    w_coal_cnt = '0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      w_coal_cnt = w_coal_cnt + C_POP_W'(w_coal[i]);
    end
  end

  // A clear and a coalesce in the same cycle leave only the new drops counted
  assign w_drop_base = clear_ovf ? 8'd0 : r_drop_count;
  assign w_drop_sum  = {1'b0, w_drop_base} + 9'(w_coal_cnt);
  assign w_drop_nxt  = w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
  assign w_ovf_nxt   = (w_coal_cnt != '0) | (r_overflow & ~clear_ovf);

  // Edge history, pending set and timestamp counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_alarm_q <= '0;
      r_pending <= '0;
      r_ts_cnt  <= '0;
    end else begin
      r_alarm_q <= alarm_in;
      r_pending <= w_pending_nxt;
      r_ts_cnt  <= r_ts_cnt + TS_WIDTH'(1);
    end
  end

  // Event FIFO: entries carry the pre-edge timestamp of the enqueue cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_id[i] <= '0;
        r_mem_ts[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem_id[r_wr_ptr] <= w_sel_idx;
        r_mem_ts[r_wr_ptr] <= r_ts_cnt;
        r_wr_ptr           <= r_wr_ptr + C_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + C_PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + C_CNT_W'(1);
        2'b01:   r_count <= r_count - C_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow flag and saturating drop counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else begin
      r_overflow   <= w_ovf_nxt;
      r_drop_count <= w_drop_nxt;
    end
  end

  // Show-ahead outputs read straight from registered state
  always_comb begin
    evt_valid  = (r_count != '0);
    evt_id     = evt_valid ? r_mem_id[r_rd_ptr] : '0;
    evt_ts     = evt_valid ? r_mem_ts[r_rd_ptr] : '0;
    fifo_count = r_count;
    overflow   = r_overflow;
    drop_count = r_drop_count;
    irq        = evt_valid | r_overflow;
  end

endmodule
`default_nettype wire

// File: tb/tb_ats21_alarm_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_ats21_alarm_collector
// Purpose  : Scoreboard bench for ats21_alarm_collector. A reference model
//            updated on every clock edge pushes expected events; a monitor
//            pops them whenever the DUT hands an event to the reader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ats21_alarm_collector;

  localparam int NA  = 24;
  localparam int DP  = 8;
  localparam int TSW = 8;
  localparam int IDW = 5;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [NA-1:0]  alarm_in = '0;
  logic           enable = 1'b1;
  logic           rd_en = 1'b0;
  logic           clear_ovf = 1'b0;
  logic           evt_valid;
  logic [IDW-1:0] evt_id;
  logic [TSW-1:0] evt_ts;
  logic [3:0]     fifo_count;
  logic           overflow;
  logic [7:0]     drop_count;
  logic           irq;

  ats21_alarm_collector #(
    .NUM_ALARMS(NA), .DEPTH(DP), .TS_WIDTH(TSW), .ID_WIDTH(IDW)
  ) dut (
    .clk(clk), .reset(reset), .alarm_in(alarm_in), .enable(enable),
    .rd_en(rd_en), .clear_ovf(clear_ovf), .evt_valid(evt_valid),
    .evt_id(evt_id), .evt_ts(evt_ts), .fifo_count(fifo_count),
    .overflow(overflow), .drop_count(drop_count), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct { int id; int ts; } evt_t;
  evt_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state (value after the most recent edge)
  logic [NA-1:0] m_prev = '0;
  logic [NA-1:0] m_pending = '0;
  int            m_ts = 0;
  int            m_cnt = 0;
  int            m_drop = 0;
  bit            m_ovf = 1'b0;

  logic [NA-1:0] m_new, m_clr, m_coal;
  int            m_sel, m_nc;
  bit            m_push, m_pop;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending is a set of alarms awaiting a FIFO slot,
  // the FIFO is tracked as an occupancy number plus the scoreboard queue.
  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_prev = '0; m_pending = '0; m_ts = 0; m_cnt = 0;
        m_drop = 0; m_ovf = 1'b0; sb.delete();
      end else begin
        m_new  = alarm_in & ~m_prev & {NA{enable}};
        m_pop  = rd_en && (m_cnt > 0);
        m_push = (m_pending != '0) && ((m_cnt < DP) || m_pop);
        m_clr  = '0;
        if (m_push) begin
          m_sel = -1;
          for (int i = NA - 1; i >= 0; i--) if (m_pending[i]) m_sel = i;
          m_clr[m_sel] = 1'b1;
          sb.push_back('{m_sel, m_ts});
        end
        m_coal    = m_new & m_pending & ~m_clr;
        m_nc      = $countones(m_coal);
        m_pending = (m_pending & ~m_clr) | m_new;
        if (clear_ovf) m_drop = 0;
        if (m_nc > 0) begin
          m_drop = (m_drop + m_nc > 255) ? 255 : m_drop + m_nc;
          m_ovf  = 1'b1;
        end else if (clear_ovf) begin
          m_ovf = 1'b0;
        end
        m_cnt  = m_cnt + int'(m_push) - int'(m_pop);
        m_ts   = (m_ts + 1) % (1 << TSW);
        m_prev = alarm_in;
      end
    end
  end

  // Monitor: compares status every cycle and the head entry on each pop
  initial begin
    evt_t e;
    forever begin
      @(negedge clk);
      check("evt_valid", 32'(evt_valid), 32'(m_cnt != 0));
      check("fifo_count", 32'(fifo_count), m_cnt);
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("drop_count", 32'(drop_count), m_drop);
      check("irq", 32'(irq), 32'((m_cnt != 0) || m_ovf));
      if (!evt_valid) begin
        check("empty_id", 32'(evt_id), 0);
        check("empty_ts", 32'(evt_ts), 0);
      end else if (rd_en && !reset) begin
        if (sb.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL pop_unexpected: got id %0d ts %0h expected no event", evt_id, evt_ts);
        end else begin
          e = sb.pop_front();
          check("evt_id", 32'(evt_id), e.id);
          check("evt_ts", 32'(evt_ts), e.ts);
        end
      end
    end
  end

  task automatic drive(input logic [NA-1:0] a, input logic en, input logic rd, input logic clr);
    @(posedge clk);
    #2;
    alarm_in = a; enable = en; rd_en = rd; clear_ovf = clr;
  endtask

  task automatic idle(input int n, input logic rd);
    for (int k = 0; k < n; k++) drive('0, 1'b1, rd, 1'b0);
  endtask

  task automatic pulse(input logic [NA-1:0] a, input logic en);
    drive(a, en, 1'b0, 1'b0);
    drive(a, en, 1'b0, 1'b0);
    drive('0, en, 1'b0, 1'b0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;

    // Single event on alarm 3, then one pop
    idle(2, 1'b0);
    pulse(24'h000008, 1'b1);
    idle(3, 1'b0);
    idle(1, 1'b1);
    idle(2, 1'b0);

    // Simultaneous rises on 0, 5 and 23
    pulse(24'h800021, 1'b1);
    idle(4, 1'b0);
    idle(4, 1'b1);

    // Ten distinct rises with no reads, one pop, then full drain
    pulse(24'h03FF00, 1'b1);
    idle(12, 1'b0);
    idle(1, 1'b1);
    idle(3, 1'b0);
    idle(12, 1'b1);

    // Fill FIFO, park alarm 7 as pending, then re-rise it twice
    pulse(24'h03FC00, 1'b1);
    idle(9, 1'b0);
    pulse(24'h000080, 1'b1);
    pulse(24'h000080, 1'b1);
    drive(24'h000080, 1'b1, 1'b0, 1'b1);
    drive('0, 1'b1, 1'b0, 1'b0);
    drive('0, 1'b1, 1'b0, 1'b1);
    idle(12, 1'b1);

    // Disabled capture ignores a rise on alarm 2
    pulse(24'h000004, 1'b0);
    idle(3, 1'b1);

    // Randomised traffic: slow reader then fast reader; crosses ts wrap
    for (int k = 0; k < 600; k++)
      drive(NA'($urandom & $urandom & $urandom & $urandom), ($urandom_range(0, 15) != 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 63) == 0));
    for (int k = 0; k < 600; k++)
      drive(NA'($urandom & $urandom & $urandom & $urandom), ($urandom_range(0, 15) != 0),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 63) == 0));

    // Asynchronous reset with entries queued and alarms pending
    pulse(24'h00007E, 1'b1);
    idle(3, 1'b0);
    @(posedge clk);
    #4 reset = 1'b1;
    #1;
    check("rst_evt_valid", 32'(evt_valid), 0);
    check("rst_fifo_count", 32'(fifo_count), 0);
    check("rst_irq", 32'(irq), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_evt_id", 32'(evt_id), 0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    idle(10, 1'b1);

    // Post-reset event still works, then everything drains
    pulse(24'h000400, 1'b1);
    idle(20, 1'b1);
    check("scoreboard_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
